reset_conduit_sequencer: RTL and testbench

//  Multi-channel reset conduit that sequences reset release. NUM_CH async reset requests are synchronised

---
 rtl/reset_conduit_sequencer.sv | 136 +++++++++++++
 tb/tb_reset_conduit_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/reset_conduit_sequencer.sv
// Multi-channel reset conduit: synchronises async reset requests and releases the
// channel resets one at a time in ascending index order after a stretch and per-channel gap.
//
// state   | meaning
// HOLD    | a request is (or was just) active; outputs held, timing restarts next cycle
// STRETCH | counting the minimum hold before releasing the first pending channel
// GAP     | counting the spacing before releasing the next channel
// DONE    | every channel released, release_done high
module reset_conduit_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int RELEASE_DELAY  = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_CH-1:0]               areset_in,
    output logic [NUM_CH-1:0]               areset_out,
    output logic                            release_done,
    output logic [$clog2(NUM_CH+1)-1:0]     seq_ptr
);

    localparam int PTR_W   = $clog2(NUM_CH + 1);
    localparam int MAX_CNT = (STRETCH_CYCLES > RELEASE_DELAY) ? STRETCH_CYCLES : RELEASE_DELAY;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] STRETCH_TC = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC     = CNT_W'(RELEASE_DELAY - 1);
    localparam logic [PTR_W-1:0] PTR_END    = PTR_W'(NUM_CH);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        GAP     = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [PTR_W-1:0]                    ptr_q, ptr_d;
    logic [NUM_CH-1:0]                   out_q, out_d;
    logic                                done_q, done_d;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0]  sync_q;
    logic [NUM_CH-1:0]                   req_q;

    logic                                any_req;
    logic                                rel_now;
    logic [PTR_W-1:0]                    min_req;
    logic [PTR_W-1:0]                    lo_ptr;

    // Extra registered stage after the synchroniser gives the request path one full
    // clock to fan out into the priority encoder and pointer compare.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
            req_q  <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], areset_in};
            req_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            ptr_q   <= '0;
            out_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        min_req = PTR_END;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_q[i]) min_req = PTR_W'(i);
        end
        any_req = |req_q;
        lo_ptr  = (min_req < ptr_q) ? min_req : ptr_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        rel_now = 1'b0;

        if (any_req) begin
            state_d = HOLD;
            ptr_d   = lo_ptr;
            cnt_d   = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    state_d = STRETCH;
                    cnt_d   = '0;
                end
                STRETCH: begin
                    if (cnt_q == STRETCH_TC) rel_now = 1'b1;
                    else                     cnt_d   = cnt_q + CNT_W'(1);
                end
                GAP: begin
                    if (cnt_q == GAP_TC) rel_now = 1'b1;
                    else                 cnt_d   = cnt_q + CNT_W'(1);
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end

        if (rel_now) begin
            ptr_d   = ptr_q + PTR_W'(1);
            cnt_d   = '0;
            state_d = (ptr_d == PTR_END) ? DONE : GAP;
        end

        // Outputs are a pure thermometer of the pointer, so ordering can never invert.
        for (int j = 0; j < NUM_CH; j++) begin
            out_d[j] = (PTR_W'(j) >= ptr_d);
        end
        done_d = (state_d == DONE);
    end

    assign areset_out   = out_q;
    assign release_done = done_q;
    assign seq_ptr      = ptr_q;

endmodule

// File: tb/tb_reset_conduit_sequencer.sv
// Directed bench for reset_conduit_sequencer: edge-indexed expectations for power-up,
// re-requests from DONE/GAP/STRETCH, request-vs-release collision and mid-sequence reset.
module tb_reset_conduit_sequencer;

    localparam int NUM_CH = 4;

    logic              clock;
    logic              reset;
    logic [NUM_CH-1:0] areset_in;
    logic [NUM_CH-1:0] areset_out;
    logic              release_done;
    logic [2:0]        seq_ptr;

    int n_chk  = 0;
    int n_fail = 0;
    int e      = -100;

    reset_conduit_sequencer #(
        .NUM_CH         (NUM_CH),
        .SYNC_STAGES    (2),
        .STRETCH_CYCLES (16),
        .RELEASE_DELAY  (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .areset_in    (areset_in),
        .areset_out   (areset_out),
        .release_done (release_done),
        .seq_ptr      (seq_ptr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    task automatic expect_st(input string tag, input logic [3:0] out,
                             input logic [2:0] ptr, input logic done);
        chk({tag, ".out"},  32'(areset_out),   32'(out));
        chk({tag, ".ptr"},  32'(seq_ptr),      32'(ptr));
        chk({tag, ".done"}, 32'(release_done), 32'(done));
    endtask

    // Advance until edge n has occurred; sampling and driving happen 1 time unit after it.
    task automatic at(input int n);
        while (e < n) begin
            @(posedge clock);
            #1;
            e++;
        end
    endtask

    always @(negedge clock) begin
        chk("thermo", 32'(areset_out[NUM_CH-2:0] & ~areset_out[NUM_CH-1:1]), 32'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", e);
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        areset_in = '0;
        repeat (3) @(posedge clock);
        #1;
        expect_st("rst", 4'b1111, 3'd0, 1'b0);
        reset = 1'b0;
        e     = -1;

        // 1: power-up release sequence
        at(3);  expect_st("s1.e3",  4'b1111, 3'd0, 1'b0);
        at(18); expect_st("s1.e18", 4'b1111, 3'd0, 1'b0);
        at(19); expect_st("s1.e19", 4'b1110, 3'd1, 1'b0);
        at(26); expect_st("s1.e26", 4'b1110, 3'd1, 1'b0);
        at(27); expect_st("s1.e27", 4'b1100, 3'd2, 1'b0);
        at(35); expect_st("s1.e35", 4'b1000, 3'd3, 1'b0);
        at(42); expect_st("s1.e42", 4'b1000, 3'd3, 1'b0);
        at(43); expect_st("s1.e43", 4'b0000, 3'd4, 1'b1);

        // 2: channel 2 requested from DONE for 5 clocks
        at(50); areset_in = 4'b0100;
        at(53); expect_st("s2.e53", 4'b0000, 3'd4, 1'b1);
        at(54); expect_st("s2.e54", 4'b1100, 3'd2, 1'b0);
        at(55); areset_in = 4'b0000;
        at(74); expect_st("s2.e74", 4'b1100, 3'd2, 1'b0);
        at(75); expect_st("s2.e75", 4'b1000, 3'd3, 1'b0);
        at(82); expect_st("s2.e82", 4'b1000, 3'd3, 1'b0);
        at(83); expect_st("s2.e83", 4'b0000, 3'd4, 1'b1);

        // 3: channel 0 request in GAP with seq_ptr=2
        at(85);  areset_in = 4'b0001;
        at(86);  areset_in = 4'b0000;
        at(89);  expect_st("s3.e89",  4'b1111, 3'd0, 1'b0);
        at(106); expect_st("s3.e106", 4'b1110, 3'd1, 1'b0);
        at(114); expect_st("s3.e114", 4'b1100, 3'd2, 1'b0);
        at(117); areset_in = 4'b0001;
        at(118); areset_in = 4'b0000;
        at(120); expect_st("s3.e120", 4'b1100, 3'd2, 1'b0);
        at(121); expect_st("s3.e121", 4'b1111, 3'd0, 1'b0);
        at(137); expect_st("s3.e137", 4'b1111, 3'd0, 1'b0);
        at(138); expect_st("s3.e138", 4'b1110, 3'd1, 1'b0);
        at(161); expect_st("s3.e161", 4'b1000, 3'd3, 1'b0);
        at(162); expect_st("s3.e162", 4'b0000, 3'd4, 1'b1);

        // 4: channel 3 pulse during STRETCH with seq_ptr=1 restarts the stretch
        at(164); areset_in = 4'b0010;
        at(165); areset_in = 4'b0000;
        at(168); expect_st("s4.e168", 4'b1110, 3'd1, 1'b0);
        at(172); areset_in = 4'b1000;
        at(173); areset_in = 4'b0000;
        at(176); expect_st("s4.e176", 4'b1110, 3'd1, 1'b0);
        at(185); expect_st("s4.e185", 4'b1110, 3'd1, 1'b0);
        at(192); expect_st("s4.e192", 4'b1110, 3'd1, 1'b0);
        at(193); expect_st("s4.e193", 4'b1100, 3'd2, 1'b0);
        at(209); expect_st("s4.e209", 4'b0000, 3'd4, 1'b1);

        // 5: request lands on the edge channel 1 would release
        at(211); areset_in = 4'b0010;
        at(212); areset_in = 4'b0000;
        at(215); expect_st("s5.e215", 4'b1110, 3'd1, 1'b0);
        at(228); areset_in = 4'b0100;
        at(229); areset_in = 4'b0000;
        at(231); expect_st("s5.e231", 4'b1110, 3'd1, 1'b0);
        at(232); expect_st("s5.e232", 4'b1110, 3'd1, 1'b0);
        at(248); expect_st("s5.e248", 4'b1110, 3'd1, 1'b0);
        at(249); expect_st("s5.e249", 4'b1100, 3'd2, 1'b0);
        at(257); expect_st("s5.e257", 4'b1000, 3'd3, 1'b0);

        // 6: reset in GAP with seq_ptr=3, then a clean power-up again
        at(260); expect_st("s6.e260", 4'b1000, 3'd3, 1'b0);
        reset = 1'b1;
        at(261); expect_st("s6.e261", 4'b1111, 3'd0, 1'b0);
        at(262);
        reset = 1'b0;
        e     = -1;
        at(18); expect_st("s6.p18", 4'b1111, 3'd0, 1'b0);
        at(19); expect_st("s6.p19", 4'b1110, 3'd1, 1'b0);
        at(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
